// File: rtl/cga_vram_arbiter.sv
// CGA video RAM arbiter: shares one SRAM between the video fetch sequencer and
// ISA CPU accesses, giving video priority until a CPU request has waited too long.
module cga_vram_arbiter #(
    parameter logic [19:0] FRAMEBUFFER_ADDR = 20'hB8000,
    parameter int          USE_BUS_WAIT     = 0,
    parameter logic [4:0]  SLOT_TIMEOUT     = 5'd24
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] bus_a,
    input  logic        bus_memr_l,
    input  logic        bus_memw_l,
    input  logic        bus_aen,
    input  logic [7:0]  bus_d,
    output logic [7:0]  bus_out,
    output logic        bus_dir,
    output logic        bus_rdy,
    input  logic        vid_read,
    input  logic [18:0] vid_a,
    output logic [7:0]  vid_d,
    output logic [18:0] ram_a,
    output logic        ram_we_l,
    input  logic [7:0]  ram_din,
    output logic [7:0]  ram_dout,
    output logic        snow
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_SLOT,
        ST_ACCESS,
        ST_HOLD
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [1:0]  r_memr_sync;
    logic [1:0]  r_memw_sync;
    logic [4:0]  r_wait_cnt;
    logic [4:0]  w_wait_cnt_next;
    logic [18:0] r_cpu_addr;
    logic [7:0]  r_cpu_data;
    logic        r_is_write;
    logic [7:0]  r_bus_out;

    logic w_memr_active;
    logic w_memw_active;
    logic w_decode;
    logic w_rd_req;
    logic w_wr_req;
    logic w_req;
    logic w_strobe_held;
    logic w_latch;
    logic w_in_access;
    logic w_cpu_we;

    // Strobes are asynchronous to clk; bit 1 is the synchronized copy.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_memr_sync <= 2'b11;
            r_memw_sync <= 2'b11;
        end else begin
            r_memr_sync <= {r_memr_sync[0], bus_memr_l};
            r_memw_sync <= {r_memw_sync[0], bus_memw_l};
        end
    end

    assign w_memr_active = ~r_memr_sync[1];
    assign w_memw_active = ~r_memw_sync[1];
    assign w_decode      = ~bus_aen && (bus_a[19:15] == FRAMEBUFFER_ADDR[19:15]);
    assign w_rd_req      = w_decode && w_memr_active;
    assign w_wr_req      = w_decode && w_memw_active;
    assign w_req         = w_rd_req || w_wr_req;
    assign w_strobe_held = r_is_write ? w_memw_active : w_memr_active;

    always_comb begin
        w_state_next    = r_state;
        w_wait_cnt_next = r_wait_cnt;
        w_latch         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_wait_cnt_next = 5'd0;
                if (w_req) begin
                    w_latch      = 1'b1;
                    w_state_next = ST_WAIT_SLOT;
                end
            end
            ST_WAIT_SLOT: begin
                if (!w_strobe_held) begin
                    w_state_next = ST_IDLE;
                end else if (!vid_read || (r_wait_cnt == SLOT_TIMEOUT)) begin
                    w_state_next = ST_ACCESS;
                end else begin
                    w_wait_cnt_next = r_wait_cnt + 5'd1;
                end
            end
            ST_ACCESS: begin
                w_state_next = ST_HOLD;
            end
            ST_HOLD: begin
                // One access per ISA cycle: wait for the strobe to go away.
                if (!w_strobe_held) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= 5'd0;
            r_cpu_addr <= 19'd0;
            r_cpu_data <= 8'h00;
            r_is_write <= 1'b0;
            r_bus_out  <= 8'h00;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_cnt_next;
            if (w_latch) begin
                r_cpu_addr <= {4'b0001, bus_a[14:0]};
                r_cpu_data <= bus_d;
                r_is_write <= w_wr_req;
            end
            if ((r_state == ST_ACCESS) && !r_is_write) begin
                r_bus_out <= ram_din;
            end
        end
    end

    // Reset drops the write enable immediately so an interrupted write never lands.
    assign w_in_access = (r_state == ST_ACCESS);
    assign w_cpu_we    = w_in_access && r_is_write && !reset;

    assign ram_a    = w_in_access ? r_cpu_addr : vid_a;
    assign ram_we_l = ~w_cpu_we;
    assign ram_dout = r_cpu_data;
    assign vid_d    = ram_din;
    assign snow     = w_in_access && vid_read;
    assign bus_dir  = w_rd_req;
    assign bus_out  = r_bus_out;

    generate
        if (USE_BUS_WAIT != 0) begin : g_bus_wait
            assign bus_rdy = ~(((r_state == ST_IDLE) && w_req)
                               || (r_state == ST_WAIT_SLOT)
                               || (r_state == ST_ACCESS));
        end else begin : g_no_bus_wait
            assign bus_rdy = 1'b1;
        end
    endgenerate

endmodule

// File: tb/tb_cga_vram_arbiter.sv
// Bench for cga_vram_arbiter: SRAM model, ISA-cycle level reference model,
// per-cycle comparison, directed scenarios and randomized ISA traffic.
module tb_cga_vram_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset      = 1'b1;
    logic [19:0] bus_a      = 20'h0;
    logic        bus_memr_l = 1'b1;
    logic        bus_memw_l = 1'b1;
    logic        bus_aen    = 1'b0;
    logic [7:0]  bus_d      = 8'h00;
    logic        vid_read   = 1'b0;
    logic [18:0] vid_a      = 19'h0;

    wire [7:0]  bus_out, vid_d, ram_din, ram_dout;
    wire        bus_dir, bus_rdy, ram_we_l, snow;
    wire [18:0] ram_a;
    wire [7:0]  bus_out2, vid_d2, ram_dout2;
    wire        bus_dir2, bus_rdy2, ram_we_l2, snow2;
    wire [18:0] ram_a2;

    cga_vram_arbiter #(.FRAMEBUFFER_ADDR(20'hB8000), .USE_BUS_WAIT(1), .SLOT_TIMEOUT(5'd24)) dut (
        .clk(clk), .reset(reset), .bus_a(bus_a), .bus_memr_l(bus_memr_l),
        .bus_memw_l(bus_memw_l), .bus_aen(bus_aen), .bus_d(bus_d),
        .bus_out(bus_out), .bus_dir(bus_dir), .bus_rdy(bus_rdy),
        .vid_read(vid_read), .vid_a(vid_a), .vid_d(vid_d),
        .ram_a(ram_a), .ram_we_l(ram_we_l), .ram_din(ram_din),
        .ram_dout(ram_dout), .snow(snow)
    );

    // Second copy without bus wait: only its bus_rdy is of interest.
    cga_vram_arbiter #(.FRAMEBUFFER_ADDR(20'hB8000), .USE_BUS_WAIT(0), .SLOT_TIMEOUT(5'd24)) dut_nowait (
        .clk(clk), .reset(reset), .bus_a(bus_a), .bus_memr_l(bus_memr_l),
        .bus_memw_l(bus_memw_l), .bus_aen(bus_aen), .bus_d(bus_d),
        .bus_out(bus_out2), .bus_dir(bus_dir2), .bus_rdy(bus_rdy2),
        .vid_read(vid_read), .vid_a(vid_a), .vid_d(vid_d2),
        .ram_a(ram_a2), .ram_we_l(ram_we_l2), .ram_din(ram_din),
        .ram_dout(ram_dout2), .snow(snow2)
    );

    function automatic logic [7:0] init_pat(input logic [18:0] a);
        return a[7:0] ^ a[15:8] ^ {5'b0, a[18:16]} ^ 8'h3C;
    endfunction

    // Asynchronous SRAM driven by the main DUT.
    logic [7:0] sram [0:524287];
    assign ram_din = sram[ram_a];
    always @(posedge clk) if (ram_we_l === 1'b0) sram[ram_a] <= ram_dout;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] ref_mem [int];
    function automatic logic [7:0] ref_rd(input logic [18:0] a);
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        return init_pat(a);
    endfunction

    function automatic bit in_window(input logic [19:0] a, input logic aen);
        return !aen && (a[19:15] == 5'h17);
    endfunction

    bit          m_valid = 0;
    bit          m_r1 = 1, m_r2 = 1, m_w1 = 1, m_w2 = 1;   // strobe delay lines
    bit          m_open = 0;        // CPU ISA cycle accepted and not yet finished
    bit          m_served = 0;      // its single RAM access has happened
    bit          m_access_now = 0;  // this clock cycle is the RAM access
    int          m_wait = 0;
    logic [18:0] m_addr = 19'h0;
    logic [7:0]  m_data = 8'h00;
    bit          m_write = 0;
    logic [7:0]  m_bus_out = 8'h00;

    always @(posedge clk) begin : model
        bit rd_s, wr_s, held;
        rd_s = !m_r2;
        wr_s = !m_w2;
        if (reset) begin
            m_valid = 1; m_open = 0; m_served = 0; m_access_now = 0; m_wait = 0;
            m_bus_out = 8'h00; m_r1 = 1; m_r2 = 1; m_w1 = 1; m_w2 = 1;
        end else begin
            held = m_write ? wr_s : rd_s;
            if (m_access_now) begin
                if (m_write) ref_mem[int'(m_addr)] = m_data;
                else m_bus_out = ref_rd(m_addr);
                m_access_now = 0;
                m_served = 1;
            end else if (m_open && !m_served) begin
                if (!held) m_open = 0;
                else if (!vid_read || m_wait == 24) m_access_now = 1;
                else m_wait++;
            end else if (m_open) begin
                if (!held) m_open = 0;
            end else if (in_window(bus_a, bus_aen) && (rd_s || wr_s)) begin
                m_open = 1; m_served = 0; m_wait = 0;
                m_addr = {4'b0001, bus_a[14:0]};
                m_data = bus_d;
                m_write = wr_s;
            end
            m_r2 = m_r1; m_r1 = bus_memr_l;
            m_w2 = m_w1; m_w1 = bus_memw_l;
        end
    end

    int c_we = 0, c_snow = 0, c_rdylow = 0, c_dir = 0;

    always @(negedge clk) begin : cmp
        logic [18:0] ea;
        bit rd_s, wr_s, dec, req;
        if (m_valid) begin
            dec  = in_window(bus_a, bus_aen);
            rd_s = !m_r2;
            wr_s = !m_w2;
            req  = dec && (rd_s || wr_s);
            ea   = m_access_now ? m_addr : vid_a;
            chk("ram_a", 32'(ram_a), 32'(ea));
            chk("ram_we_l", 32'(ram_we_l), 32'(!(m_access_now && m_write && !reset)));
            if (m_access_now && m_write) chk("ram_dout", 32'(ram_dout), 32'(m_data));
            chk("snow", 32'(snow), 32'(m_access_now && vid_read));
            chk("bus_dir", 32'(bus_dir), 32'(dec && rd_s));
            chk("bus_rdy", 32'(bus_rdy), 32'(!((!m_open && req) || (m_open && !m_served))));
            chk("bus_out", 32'(bus_out), 32'(m_bus_out));
            chk("vid_d", 32'(vid_d), 32'(ref_rd(ea)));
            chk("bus_rdy_nowait", 32'(bus_rdy2), 32'd1);
            if (ram_we_l === 1'b0) c_we++;
            if (snow === 1'b1) c_snow++;
            if (bus_rdy === 1'b0) c_rdylow++;
            if (bus_dir === 1'b1) c_dir++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clr_cnt();
        c_we = 0; c_snow = 0; c_rdylow = 0; c_dir = 0;
    endtask

    initial begin
        for (int i = 0; i < 524288; i++) sram[i] = init_pat(19'(i));
        ticks(3);
        reset = 1'b0;
        #1;
        chk("reset_bus_out", 32'(bus_out), 32'h00);
        chk("reset_we_l", 32'(ram_we_l), 32'd1);
        chk("reset_rdy", 32'(bus_rdy), 32'd1);
        chk("reset_snow", 32'(snow), 32'd0);

        // Video-only traffic
        vid_a = 19'h08000;
        for (int i = 0; i < 6; i++) begin
            tick();
            vid_read = i[0];
            #1;
            chk("vid_ram_a", 32'(ram_a), 32'h08000);
            chk("vid_snow", 32'(snow), 32'd0);
            chk("vid_d_lit", 32'(vid_d), 32'hBC);
        end
        vid_read = 1'b0;

        // Write 0x5A to B8123 with free slots
        tick();
        bus_a = 20'hB8123; bus_d = 8'h5A; bus_memw_l = 1'b0; clr_cnt();
        ticks(8);
        bus_memw_l = 1'b1;
        ticks(4);
        chk("wr_we_cycles", 32'(c_we), 32'd1);
        chk("wr_rdy_low", 32'(c_rdylow), 32'd3);
        chk("wr_sram", 32'(sram[19'h08123]), 32'h5A);

        // Read from BBFFF after preloading 0xC3
        sram[19'h0BFFF] = 8'hC3;
        ref_mem[int'(19'h0BFFF)] = 8'hC3;
        bus_a = 20'hBBFFF; bus_memr_l = 1'b0; clr_cnt();
        ticks(8);
        #1;
        chk("rd_bus_dir", 32'(bus_dir), 32'd1);
        chk("rd_bus_out", 32'(bus_out), 32'hC3);
        bus_memr_l = 1'b1;
        ticks(3);
        #1;
        chk("rd_dir_off", 32'(bus_dir), 32'd0);

        // Timeout steal with video holding every slot
        tick();
        vid_read = 1'b1; bus_a = 20'hB8200; bus_d = 8'h77; bus_memw_l = 1'b0; clr_cnt();
        ticks(35);
        chk("to_snow", 32'(c_snow), 32'd1);
        chk("to_rdy_low", 32'(c_rdylow), 32'd27);
        chk("to_we", 32'(c_we), 32'd1);
        bus_memw_l = 1'b1;
        ticks(4);
        vid_read = 1'b0;

        // Outside the window, then DMA cycle
        bus_a = 20'hB0000; bus_memw_l = 1'b0; clr_cnt();
        ticks(6);
        bus_memw_l = 1'b1;
        ticks(3);
        chk("out_we", 32'(c_we), 32'd0);
        chk("out_rdy", 32'(c_rdylow), 32'd0);
        bus_aen = 1'b1; bus_a = 20'hB8000; bus_memr_l = 1'b0; bus_memw_l = 1'b0; clr_cnt();
        ticks(6);
        bus_memr_l = 1'b1; bus_memw_l = 1'b1;
        ticks(3);
        chk("aen_we", 32'(c_we), 32'd0);
        chk("aen_dir", 32'(c_dir), 32'd0);
        chk("aen_rdy", 32'(c_rdylow), 32'd0);
        bus_aen = 1'b0;

        // Strobe released while waiting for a slot
        vid_read = 1'b1; bus_a = 20'hB8300; bus_d = 8'hEE; bus_memw_l = 1'b0; clr_cnt();
        ticks(2);
        bus_memw_l = 1'b1;
        ticks(6);
        chk("abort_we", 32'(c_we), 32'd0);
        chk("abort_sram", 32'(sram[19'h08300]), 32'(init_pat(19'h08300)));
        vid_read = 1'b0;

        // Reset during a write access
        bus_a = 20'hB8400; bus_d = 8'h11; bus_memw_l = 1'b0;
        ticks(4);
        #1;
        chk("rst_acc_we_before", 32'(ram_we_l), 32'd0);
        reset = 1'b1;
        #1;
        chk("rst_acc_we_after", 32'(ram_we_l), 32'd1);
        tick();
        reset = 1'b0; bus_memw_l = 1'b1;
        ticks(3);
        chk("rst_acc_sram", 32'(sram[19'h08400]), 32'(init_pat(19'h08400)));

        // Randomized ISA traffic
        for (int t = 0; t < 250; t++) begin
            int sel, hold, gap;
            bit hog;
            sel  = $urandom_range(0, 5);
            hold = $urandom_range(1, 40);
            gap  = $urandom_range(2, 5);
            hog  = ($urandom_range(0, 3) == 0);
            bus_a   = {($urandom_range(0, 7) == 0) ? 5'h16 : 5'h17, 15'($urandom_range(0, 255))};
            bus_aen = ($urandom_range(0, 9) == 0);
            bus_d   = 8'($urandom);
            bus_memw_l = !(sel <= 2 || sel == 5);
            bus_memr_l = !(sel >= 3);
            for (int i = 0; i < hold; i++) begin
                vid_read = hog ? 1'b1 : 1'($urandom_range(0, 1));
                vid_a    = ($urandom_range(0, 1) == 0) ? 19'(32'h08000 + $urandom_range(0, 255)) : 19'($urandom);
                tick();
            end
            bus_memr_l = 1'b1; bus_memw_l = 1'b1;
            for (int i = 0; i < gap; i++) begin
                vid_read = 1'($urandom_range(0, 1));
                tick();
            end
            bus_aen = 1'b0;
            if ($urandom_range(0, 49) == 0) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
            end
        end
        ticks(4);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
